rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 SHALL take parameter ROB_SZ, default `ROB_SZ (32), the number of entries (power of two); index width IW = $clog2(ROB_SZ).
REQ-002 SHALL take parameter PR_W, default $clog2(`PHYS_REG_SZ), the phys_reg field width inside TAG.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 complete_idx  input  IW  ROB index to mark complete.
REQ-006 complete_en  input  1  qualifies complete_idx.
REQ-007 t_in  input  TAG  destination physical tag of the dispatching instruction.
REQ-008 t_old_in  input  TAG  previous mapping of that destination.
REQ-009 in_en  input  1  dispatch request; write entry at free_idx.
REQ-010 free  output  1  high when at least one entry is empty; free_idx is invalid when low.
REQ-011 free_idx  output  IW  tail index (next allocation slot).
REQ-012 head_idx_dbg  output  IW  current head index (debug).
REQ-013 retire_t  output  TAG  head entry's t, for arch map.
REQ-014 retire_t_old  output  TAG  head entry's t_old, for arch map and free list.
REQ-015 retire_en  output  1  head entry retires this cycle.

Function
REQ-016 SHALL be a circular buffer with head, tail and count (IW+1 bits); each entry holds valid, complete, t, t_old.
REQ-017 free SHALL equal (count < ROB_SZ), from registered state only (no same-cycle retire bypass); free_idx SHALL equal tail.
REQ-018 On a clock edge with in_en && free: entry[tail] <= {valid=1, complete=0, t_in, t_old_in}; tail <= tail+1 mod ROB_SZ; in_en with !free SHALL be ignored.
REQ-019 On a clock edge with complete_en: if entry[complete_idx].valid, set its complete bit; completes to invalid entries SHALL be ignored.
REQ-020 retire_en SHALL be combinational: entry[head].valid && entry[head].complete; one retirement per cycle maximum.
REQ-021 retire_t/retire_t_old SHALL show entry[head] fields when retire_en, else all-zero.
REQ-022 On a clock edge with retire_en: entry[head].valid and .complete <= 0; head <= head+1 mod ROB_SZ.
REQ-023 count SHALL increment on dispatch only, decrement on retire only, and be unchanged when both occur in the same cycle (full ROB plus retire: dispatch still blocked that cycle).
REQ-024 A completion of the head entry SHALL make it retire no earlier than the following cycle (complete bit registered).
REQ-025 head and tail SHALL wrap from ROB_SZ-1 to 0; empty is count==0, full is count==ROB_SZ (head==tail in both).

Reset
REQ-026 While reset is low: head=tail=count=0, all valid/complete bits 0; hence free=1, free_idx=0, head_idx_dbg=0, retire_en=0, retire_t=retire_t_old=0; entry t/t_old contents need not be cleared.
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously).

Structure
REQ-028 TAG (struct: phys_reg [PR_W-1:0], ready bit), `ROB_SZ and `PHYS_REG_SZ SHALL live in the shared sys_defs header; a ROB_ENTRY struct (valid, complete, t, t_old) SHALL also be defined there.
REQ-029 SHALL be one flat module; no sub-module is required.

Verification
REQ-030 Reset low then high -> free=1, free_idx=0, head_idx_dbg=0, retire_en=0.
REQ-031 Dispatch t=5,t_old=3 then t=6,t_old=4 -> free_idx=2; complete idx 1 -> retire_en stays 0 (head incomplete); complete idx 0 -> next cycle retire_en=1, retire_t=5, retire_t_old=3, then next cycle retire_t=6, retire_t_old=4, head_idx_dbg=2.
REQ-032 Dispatch ROB_SZ entries without completing -> free=0 after the last; extra in_en ignored (free_idx stays 0).
REQ-033 Full ROB, head complete, in_en asserted same cycle -> head retires, no allocation; next cycle free=1 and dispatch to idx 0 succeeds.
REQ-034 Run 2*ROB_SZ dispatch/complete/retire cycles -> head and tail wrap; retire order matches dispatch order.
REQ-035 complete_en on an empty slot (idx 7, empty ROB) -> no effect; later dispatch to idx 7 is incomplete.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared ROB definitions: default sizes, physical-register tag and entry layout.
package rob_pkg;

    localparam int unsigned DEF_ROB_SZ      = 32;
    localparam int unsigned DEF_PHYS_REG_SZ = 64;
    localparam int unsigned TAG_PR_W        = $clog2(DEF_PHYS_REG_SZ);

    typedef struct packed {
        logic [TAG_PR_W-1:0] phys_reg;
        logic                ready;
    } tag_t;

    typedef struct packed {
        logic valid;
        logic complete;
        tag_t t;
        tag_t t_old;
    } rob_entry_t;

endpackage

// File: rtl/rob_if.sv
// Dispatch / complete / retire bundle between the ROB and its surroundings.
interface rob_if
    import rob_pkg::*;
#(
    parameter int unsigned IW = $clog2(DEF_ROB_SZ)
) ();

    logic [IW-1:0] complete_idx;
    logic          complete_en;
    tag_t          t_in;
    tag_t          t_old_in;
    logic          in_en;
    logic          free;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] head_idx_dbg;
    tag_t          retire_t;
    tag_t          retire_t_old;
    logic          retire_en;

    modport master (
        output complete_idx, complete_en, t_in, t_old_in, in_en,
        input  free, free_idx, head_idx_dbg, retire_t, retire_t_old, retire_en
    );

    modport slave (
        input  complete_idx, complete_en, t_in, t_old_in, in_en,
        output free, free_idx, head_idx_dbg, retire_t, retire_t_old, retire_en
    );

endinterface

// File: rtl/rob.sv
// Reorder buffer: circular queue that allocates in order, completes out of order
// and retires at most one completed head entry per cycle.
module rob
    import rob_pkg::*;
#(
    parameter int unsigned ROB_SZ = DEF_ROB_SZ,
    parameter int unsigned PR_W   = $clog2(DEF_PHYS_REG_SZ)
) (
    input  logic clock,
    input  logic reset,
    rob_if.slave bus
);

    localparam int unsigned IW       = $clog2(ROB_SZ);
    localparam int unsigned CW       = IW + 1;
    localparam int unsigned TW       = PR_W + 1;
    localparam int unsigned TAG_BITS = $bits(tag_t);

    logic [IW-1:0]     head_q;
    logic [IW-1:0]     tail_q;
    logic [CW-1:0]     count_q;
    logic [ROB_SZ-1:0] valid_q;
    logic [ROB_SZ-1:0] complete_q;
    logic [TW-1:0]     t_mem     [ROB_SZ];
    logic [TW-1:0]     t_old_mem [ROB_SZ];

    logic dispatch;
    logic retire;

    assign bus.free         = (count_q < CW'(ROB_SZ));
    assign bus.free_idx     = tail_q;
    assign bus.head_idx_dbg = head_q;

    assign dispatch = bus.in_en & bus.free;
    assign retire   = valid_q[head_q] & complete_q[head_q];

    assign bus.retire_en    = retire;
    assign bus.retire_t     = retire ? tag_t'(TAG_BITS'(t_mem[head_q]))     : '0;
    assign bus.retire_t_old = retire ? tag_t'(TAG_BITS'(t_old_mem[head_q])) : '0;

    // Control state; later assignments take priority (retire clears a head that is
    // completed again in the same cycle, dispatch initialises a freshly allocated slot).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            complete_q <= '0;
        end else begin
            if (bus.complete_en && valid_q[bus.complete_idx]) begin
                complete_q[bus.complete_idx] <= 1'b1;
            end
            if (retire) begin
                valid_q[head_q]    <= 1'b0;
                complete_q[head_q] <= 1'b0;
                head_q             <= head_q + IW'(1);
            end
            if (dispatch) begin
                valid_q[tail_q]    <= 1'b1;
                complete_q[tail_q] <= 1'b0;
                tail_q             <= tail_q + IW'(1);
            end
            case ({dispatch, retire})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Tag payload storage needs no reset; it is only observed behind a valid bit.
    always_ff @(posedge clock) begin
        if (dispatch) begin
            t_mem[tail_q]     <= TW'(bus.t_in);
            t_old_mem[tail_q] <= TW'(bus.t_old_in);
        end
    end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: dispatch, completion ordering, full/empty, wrap and reset.
module tb_rob;
    import rob_pkg::*;

    localparam int unsigned N  = DEF_ROB_SZ;
    localparam int unsigned IW = $clog2(N);

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    rob_if #(.IW(IW)) bus ();

    rob dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic tag_t mk(int unsigned p);
        tag_t r;
        r.phys_reg = TAG_PR_W'(p);
        r.ready    = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.in_en        = 1'b0;
        bus.complete_en  = 1'b0;
        bus.complete_idx = '0;
        bus.t_in         = '0;
        bus.t_old_in     = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        idle();

        // Reset state
        do_reset();
        check("rst_free", 32'(bus.free), 32'd1);
        check("rst_free_idx", 32'(bus.free_idx), 32'd0);
        check("rst_head", 32'(bus.head_idx_dbg), 32'd0);
        check("rst_retire_en", 32'(bus.retire_en), 32'd0);
        check("rst_retire_t", 32'(bus.retire_t), 32'd0);
        check("rst_retire_t_old", 32'(bus.retire_t_old), 32'd0);

        // Two dispatches, out-of-order completion
        bus.in_en = 1'b1; bus.t_in = mk(5); bus.t_old_in = mk(3);
        step();
        bus.t_in = mk(6); bus.t_old_in = mk(4);
        step();
        idle();
        check("two_free_idx", 32'(bus.free_idx), 32'd2);
        check("two_retire_en", 32'(bus.retire_en), 32'd0);
        bus.complete_en = 1'b1; bus.complete_idx = IW'(1);
        step();
        check("c1_no_retire", 32'(bus.retire_en), 32'd0);
        check("c1_retire_t_zero", 32'(bus.retire_t), 32'd0);
        bus.complete_idx = IW'(0);
        #1;
        check("c0_no_bypass", 32'(bus.retire_en), 32'd0);
        step();
        idle();
        check("c0_retire_en", 32'(bus.retire_en), 32'd1);
        check("c0_retire_t", 32'(bus.retire_t), 32'(mk(5)));
        check("c0_retire_t_old", 32'(bus.retire_t_old), 32'(mk(3)));
        check("c0_head", 32'(bus.head_idx_dbg), 32'd0);
        step();
        check("r1_retire_en", 32'(bus.retire_en), 32'd1);
        check("r1_retire_t", 32'(bus.retire_t), 32'(mk(6)));
        check("r1_retire_t_old", 32'(bus.retire_t_old), 32'(mk(4)));
        check("r1_head", 32'(bus.head_idx_dbg), 32'd1);
        step();
        check("r2_head", 32'(bus.head_idx_dbg), 32'd2);
        check("r2_retire_en", 32'(bus.retire_en), 32'd0);
        check("r2_retire_t", 32'(bus.retire_t), 32'd0);

        // Completion to an empty slot must be dropped
        do_reset();
        bus.complete_en = 1'b1; bus.complete_idx = IW'(7);
        step();
        idle();
        check("c7_empty_retire", 32'(bus.retire_en), 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus.in_en = 1'b1; bus.t_in = mk(20 + i); bus.t_old_in = mk(40 + i);
            step();
        end
        idle();
        for (int i = 0; i < 7; i++) begin
            bus.complete_en = 1'b1; bus.complete_idx = IW'(i);
            step();
        end
        idle();
        step();
        check("c7_head", 32'(bus.head_idx_dbg), 32'd7);
        check("c7_incomplete", 32'(bus.retire_en), 32'd0);
        bus.complete_en = 1'b1; bus.complete_idx = IW'(7);
        step();
        idle();
        check("c7_retire_en", 32'(bus.retire_en), 32'd1);
        check("c7_retire_t", 32'(bus.retire_t), 32'(mk(27)));

        // Fill to full, overflow ignored, retire-while-full blocks dispatch
        do_reset();
        for (int i = 0; i < int'(N); i++) begin
            if (i == int'(N) - 1) check("fill_free_before_last", 32'(bus.free), 32'd1);
            bus.in_en = 1'b1; bus.t_in = mk(i + 1); bus.t_old_in = mk(i + 32);
            step();
        end
        check("full_free", 32'(bus.free), 32'd0);
        check("full_free_idx", 32'(bus.free_idx), 32'd0);
        bus.t_in = mk(50);
        step();
        check("ovf_free_idx", 32'(bus.free_idx), 32'd0);
        check("ovf_free", 32'(bus.free), 32'd0);
        check("ovf_head", 32'(bus.head_idx_dbg), 32'd0);
        bus.complete_en = 1'b1; bus.complete_idx = IW'(0);
        step();
        bus.complete_en = 1'b0;
        check("fullret_retire_en", 32'(bus.retire_en), 32'd1);
        check("fullret_free", 32'(bus.free), 32'd0);
        check("fullret_retire_t", 32'(bus.retire_t), 32'(mk(1)));
        step();
        check("fullret_head", 32'(bus.head_idx_dbg), 32'd1);
        check("fullret_no_alloc", 32'(bus.free_idx), 32'd0);
        check("fullret_free_after", 32'(bus.free), 32'd1);
        step();
        idle();
        check("realloc_free_idx", 32'(bus.free_idx), 32'd1);
        check("realloc_free", 32'(bus.free), 32'd0);

        // Streaming dispatch/complete/retire across two wraps
        do_reset();
        for (int i = 0; i < 2 * int'(N); i++) begin
            bus.in_en = 1'b1;
            bus.t_in = mk(i % 64);
            bus.t_old_in = mk((i + 7) % 64);
            bus.complete_en = (i > 0);
            bus.complete_idx = IW'(i - 1);
            step();
            check("wrap_free_idx", 32'(bus.free_idx), 32'((i + 1) % int'(N)));
            if (i == 0) begin
                check("wrap_first_no_retire", 32'(bus.retire_en), 32'd0);
            end else begin
                check("wrap_retire_en", 32'(bus.retire_en), 32'd1);
                check("wrap_retire_t", 32'(bus.retire_t), 32'(mk((i - 1) % 64)));
                check("wrap_retire_t_old", 32'(bus.retire_t_old), 32'(mk((i + 6) % 64)));
                check("wrap_head", 32'(bus.head_idx_dbg), 32'((i - 1) % int'(N)));
            end
        end
        idle();

        // Asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.in_en = 1'b1; bus.t_in = mk(i + 9); bus.t_old_in = mk(i);
            step();
        end
        idle();
        bus.complete_en = 1'b1; bus.complete_idx = IW'(0);
        step();
        idle();
        check("pre_async_retire_en", 32'(bus.retire_en), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("async_free_idx", 32'(bus.free_idx), 32'd0);
        check("async_head", 32'(bus.head_idx_dbg), 32'd0);
        check("async_retire_en", 32'(bus.retire_en), 32'd0);
        check("async_retire_t", 32'(bus.retire_t), 32'd0);
        check("async_free", 32'(bus.free), 32'd1);
        step();
        reset = 1'b1;
        step();
        check("post_async_retire_en", 32'(bus.retire_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
